// File: rtl/hold_bank_pkg.sv
// hold_bank_pkg: shared defaults and bank-select type for the ping-pong hold buffer
package hold_bank_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_SIZE = 25;
   typedef logic bank_sel_t;
endpackage

// File: rtl/hold_bank.sv
// hold_bank: one bank of SIZE elements with indexed write, whole-bank clear and parallel output
module hold_bank import hold_bank_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SIZE = DEF_SIZE
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_we,
   input  logic [$clog2(SIZE)-1:0] i_idx,
   input  logic [WIDTH-1:0]        i_data,
   input  logic                    i_clr,
   output logic [WIDTH-1:0]        o_data [SIZE]
);
   always_ff @(posedge i_clk)
      for (int i = 0; i < SIZE; i++)
         if (i_rst || i_clr) o_data[i] <= '0;
         else if (i_we && int'(i_idx) == i) o_data[i] <= i_data;
endmodule

// File: rtl/hold_bank_pingpong.sv
// hold_bank_pingpong: two-bank ping-pong window buffer; HOLD_BANK_CLEAR_EN zeroes a bank when released
module hold_bank_pingpong import hold_bank_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SIZE = DEF_SIZE
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_wr_valid,
   input  logic [$clog2(SIZE)-1:0]   i_wr_idx,
   input  logic [WIDTH-1:0]          i_wr_data,
   input  logic                      i_wr_last,
   output logic                      o_wr_ready,
   output logic                      o_rd_valid,
   input  logic                      i_rd_ready,
   output logic [WIDTH-1:0]          o_dout [SIZE],
   output logic [$clog2(SIZE+1)-1:0] o_fill_count,
   output logic                      o_err
);
   localparam int CW = $clog2(SIZE + 1);
   bank_sel_t wsel, rsel;
   logic [1:0] full, we, clr;
   logic [WIDTH-1:0] dout0 [SIZE];
   logic [WIDTH-1:0] dout1 [SIZE];
   logic idx_ok, wr_acc, rd_acc;
   assign o_wr_ready = !full[wsel];
   assign o_rd_valid = full[rsel];
   assign idx_ok = int'(i_wr_idx) < SIZE;
   assign wr_acc = i_wr_valid && o_wr_ready && idx_ok;
   assign rd_acc = o_rd_valid && i_rd_ready;
   assign we = {wr_acc && wsel == 1'b1, wr_acc && wsel == 1'b0};
`ifdef HOLD_BANK_CLEAR_EN
   assign clr = {rd_acc && rsel == 1'b1, rd_acc && rsel == 1'b0};
`else
   assign clr = '0;
`endif
   always_comb
      for (int i = 0; i < SIZE; i++) o_dout[i] = rsel ? dout1[i] : dout0[i];
   hold_bank #(.WIDTH(WIDTH), .SIZE(SIZE)) u_bank0 (
      .i_clk(i_clk), .i_rst(i_rst), .i_we(we[0]), .i_idx(i_wr_idx),
      .i_data(i_wr_data), .i_clr(clr[0]), .o_data(dout0)
   );
   hold_bank #(.WIDTH(WIDTH), .SIZE(SIZE)) u_bank1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_we(we[1]), .i_idx(i_wr_idx),
      .i_data(i_wr_data), .i_clr(clr[1]), .o_data(dout1)
   );
   // A write only targets an empty bank and a release only a full one, so both full[] updates never collide
   always_ff @(posedge i_clk)
      if (i_rst) begin
         full <= '0;
         wsel <= 1'b0;
         rsel <= 1'b0;
         o_fill_count <= '0;
         o_err <= 1'b0;
      end else begin
         if (wr_acc && i_wr_last) begin
            full[wsel] <= 1'b1;
            wsel <= ~wsel;
            o_fill_count <= '0;
         end else if (wr_acc && o_fill_count != CW'(SIZE)) o_fill_count <= o_fill_count + 1'b1;
         if (rd_acc) begin
            full[rsel] <= 1'b0;
            rsel <= ~rsel;
         end
         if (i_wr_valid && (!o_wr_ready || !idx_ok)) o_err <= 1'b1;
      end
endmodule
